// File: rtl/uart_time_cmd.sv
// Parses "Thh:mm:ss<CR>" from the UART receive stream and hands packed-BCD time to the RTC controller.
// Optional build macro TIME_CMD_RANGE_CHECK_EN rejects out-of-range time digits as they arrive.
module uart_time_cmd #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] set_hour,
  output logic [7:0] set_minute,
  output logic [7:0] set_second,
  output logic       set_req,
  input  logic       set_ack,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic       busy,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_H1, S_H0, S_C1, S_M1, S_M0, S_C2, S_S1, S_S0, S_CR, S_REQ
  } state_t;

  // Handshake: set_req is a level held from CR acceptance until set_ack is
  // sampled high; set_* are stable for the whole time set_req is high.

  state_t      r_state;
  logic [7:0]  r_sh_hour;
  logic [7:0]  r_sh_min;
  logic [7:0]  r_sh_sec;
  logic [15:0] r_tmo_cnt;
  logic [7:0]  r_set_hour;
  logic [7:0]  r_set_minute;
  logic [7:0]  r_set_second;
  logic        r_set_req;
  logic        r_cmd_ok;
  logic        r_cmd_err;
  logic        r_busy;

  logic        w_is_digit;
  logic        w_range_ok;
  logic        w_byte_ok;
  logic [3:0]  w_digit;
  state_t      w_adv_state;

  assign w_digit    = rx_data[3:0];
  assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

`ifdef TIME_CMD_RANGE_CHECK_EN
  always_comb begin
    w_range_ok = 1'b1;
    case (r_state)
      S_H1:       w_range_ok = (w_digit <= 4'd2);
      S_H0:       w_range_ok = (r_sh_hour[7:4] != 4'd2) || (w_digit <= 4'd3);
      S_M1, S_S1: w_range_ok = (w_digit <= 4'd5);
      default:    w_range_ok = 1'b1;
    endcase
  end
`else
  assign w_range_ok = 1'b1;
`endif

  always_comb begin
    w_byte_ok   = 1'b0;
    w_adv_state = S_IDLE;
    case (r_state)
      S_H1: begin w_byte_ok = w_is_digit && w_range_ok; w_adv_state = S_H0; end
      S_H0: begin w_byte_ok = w_is_digit && w_range_ok; w_adv_state = S_C1; end
      S_C1: begin w_byte_ok = (rx_data == 8'h3A);       w_adv_state = S_M1; end
      S_M1: begin w_byte_ok = w_is_digit && w_range_ok; w_adv_state = S_M0; end
      S_M0: begin w_byte_ok = w_is_digit && w_range_ok; w_adv_state = S_C2; end
      S_C2: begin w_byte_ok = (rx_data == 8'h3A);       w_adv_state = S_S1; end
      S_S1: begin w_byte_ok = w_is_digit && w_range_ok; w_adv_state = S_S0; end
      S_S0: begin w_byte_ok = w_is_digit && w_range_ok; w_adv_state = S_CR; end
      S_CR: begin w_byte_ok = (rx_data == 8'h0D);       w_adv_state = S_REQ; end
      default: begin w_byte_ok = 1'b0; w_adv_state = S_IDLE; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sh_hour    <= 8'h00;
      r_sh_min     <= 8'h00;
      r_sh_sec     <= 8'h00;
      r_tmo_cnt    <= 16'd0;
      r_set_hour   <= 8'h00;
      r_set_minute <= 8'h00;
      r_set_second <= 8'h00;
      r_set_req    <= 1'b0;
      r_cmd_ok     <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cmd_ok  <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tmo_cnt <= 16'd0;
          if (rx_valid && (rx_data == 8'h54)) begin
            r_state <= S_H1;
            r_busy  <= 1'b1;
          end
        end
        S_REQ: begin
          r_tmo_cnt <= 16'd0;
          if (set_ack) begin
            r_set_req <= 1'b0;
            r_cmd_ok  <= 1'b1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          // A strobed byte always wins over a same-cycle timeout.
          if (rx_valid) begin
            r_tmo_cnt <= 16'd0;
            if (w_byte_ok) begin
              r_state <= w_adv_state;
              case (r_state)
                S_H1: r_sh_hour[7:4] <= w_digit;
                S_H0: r_sh_hour[3:0] <= w_digit;
                S_M1: r_sh_min[7:4]  <= w_digit;
                S_M0: r_sh_min[3:0]  <= w_digit;
                S_S1: r_sh_sec[7:4]  <= w_digit;
                S_S0: r_sh_sec[3:0]  <= w_digit;
                S_CR: begin
                  r_set_hour   <= r_sh_hour;
                  r_set_minute <= r_sh_min;
                  r_set_second <= r_sh_sec;
                  r_set_req    <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              r_cmd_err <= 1'b1;
              if (rx_data == 8'h54) begin
                r_state <= S_H1;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else if (r_tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
            r_tmo_cnt <= 16'd0;
            r_cmd_err <= 1'b1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign set_hour   = r_set_hour;
  assign set_minute = r_set_minute;
  assign set_second = r_set_second;
  assign set_req    = r_set_req;
  assign cmd_ok     = r_cmd_ok;
  assign cmd_err    = r_cmd_err;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: doc/uart_time_cmd.md
# uart_time_cmd

Receive-side command parser for the RTC test design. It consumes the byte stream from the board's UART receiver (the `uart1_rx` path) and parses the ASCII time-set command `Thh:mm:ss<CR>`. On a valid command it hands packed-BCD hour/minute/second to the DS1302 controller through a request/acknowledge handshake. Together with the UART transmit path that reports the time, this closes the loop so the host can both read and set the RTC.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16'd65535: maximum number of idle clocks allowed between bytes of one command before it is aborted. Range is 1 to 65535.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `set_hour`  out  8  packed BCD hour, {tens, units}.
- `set_minute`  out  8  packed BCD minute.
- `set_second`  out  8  packed BCD second.
- `set_req`  out  1  level request to the RTC controller to write `set_*`.
- `set_ack`  in  1  RTC controller has accepted the values; sampled only while `set_req` is 1.
- `cmd_ok`  out  1  one-cycle pulse when a command completes.
- `cmd_err`  out  1  one-cycle pulse when a command is aborted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States, in order: IDLE, H1, H0, C1, M1, M0, C2, S1, S0, CR, REQ.
- IDLE: `rx_data`=0x54 ('T') moves to H1. Any other byte, including LF 0x0A, is ignored without an error.
- H1, H0, M1, M0, S1, S0 expect a digit 0x30–0x39. The digit value (`rx_data`-0x30, 4 bits) is stored into the matching nibble of the shadow registers, then the FSM advances.
- C1 and C2 expect 0x3A (':'). CR expects 0x0D.
- Unexpected byte in H1..CR:
  - if the byte is 'T': pulse `cmd_err` and go to H1 (resync);
  - otherwise: pulse `cmd_err` and go to IDLE.
- Valid 0x0D in CR: copy the shadow registers to `set_hour`, `set_minute` and `set_second`, set `set_req`=1, and enter REQ.
- REQ: all `rx_valid` bytes are dropped with no error. When `set_ack`=1: clear `set_req`, pulse `cmd_ok`, and go to IDLE.
- Timeout counter:
  - cleared on every accepted byte and whenever the FSM is in IDLE or REQ;
  - counts idle clocks in H1..CR;
  - when it reaches `TIMEOUT_CYCLES`: pulse `cmd_err` and go to IDLE.
  - REQ has no timeout.
- If an error and a timeout occur in the same cycle, only one `cmd_err` pulse is produced.
- `set_*` change only on entry to REQ. They hold their value after `cmd_ok` until the next valid command.

## Timing
- Reset values: `set_hour`, `set_minute`, `set_second` = 8'h00; `set_req`, `cmd_ok`, `cmd_err`, `busy` = 0; FSM in IDLE; shadow registers and timeout counter cleared.
- Reset asserted mid-command or in REQ: all of the above take effect immediately. No `cmd_ok` or `cmd_err` is emitted.
- CR accepted in cycle N: `set_req`=1 and `set_*` valid from cycle N+1.
- First `set_ack`=1 seen in cycle M ≥ N+1: `set_req`=0 and `cmd_ok`=1 in cycle M+1. `cmd_ok` returns to 0 in M+2.
- Bad byte in cycle N: `cmd_err`=1 in cycle N+1 only.
- Timeout: `cmd_err` asserts exactly `TIMEOUT_CYCLES`+1 clocks after the last accepted byte.
- Bytes may arrive on consecutive cycles; every byte is consumed in the cycle it is strobed.
- All outputs are registered.

## Configuration
- Macro `TIME_CMD_RANGE_CHECK_EN`.
- Defined: each digit is range-checked at the moment it arrives:
  - H1 ≤ 2;
  - H0 ≤ 3 when H1 = 2;
  - M1 ≤ 5 and S1 ≤ 5.
  - A digit that fails is treated as an unexpected byte (`cmd_err`, then IDLE or H1 by the rule above).
- Not defined: any 0–9 digit is accepted and passed through unchanged, e.g. "T99:99:99\r" gives 8'h99 on all three outputs.

## Test plan
- Send "T12:34:56\r" back-to-back; hold `set_ack` 3 cycles after `set_req` rises. Expect: `set_hour`=8'h12, `set_minute`=8'h34, `set_second`=8'h56; `set_req` high 4 cycles; one `cmd_ok` pulse; no `cmd_err`.
- Send "T1x" then "T08:00:00\r". Expect: one `cmd_err` at 'x'; final `set_*`=8'h08/8'h00/8'h00 and `cmd_ok`.
- Send "T12:3", then stay idle, with `TIMEOUT_CYCLES`=100. Expect: `cmd_err` 101 clocks after '3'; `busy`=0 afterwards; `set_*` unchanged.
- With the macro defined, send "T24:00:00\r". Expect: `cmd_err` on '4' and no `set_req`. Without the macro: `set_hour`=8'h24 and `cmd_ok`.
- While in REQ with `set_ack` low, send "T11:11:11\r". Expect: the bytes are dropped and `set_*` are unchanged. Then raise `set_ack`. Expect: `cmd_ok`, then IDLE.
- Assert `rst_n`=0 while in REQ. Expect: `set_req`, `busy` and `set_*` read 0 immediately, and no `cmd_ok`.
